// File: rtl/risc_datapath_pkg.sv
// Shared constants for the single-bus RISC datapath: word width and ALU opcodes.
package risc_pkg;

    localparam int WORD = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;

endpackage

// File: rtl/risc_datapath_if.sv
// Control bundle of the datapath: register selects/enables, MDR input, ALU opcode, bus injection.
interface risc_datapath_if;

    logic [15:0] regIn;
    logic        HiIn;
    logic        LoIn;
    logic        ZIn;
    logic        PCIn;
    logic        MDRIn;
    logic        YIn;
    logic [15:0] regOut;
    logic        HiOut;
    logic        LoOut;
    logic        ZHiOut;
    logic        ZLoOut;
    logic        PCOut;
    logic        MDROut;
    logic [31:0] Mdata;
    logic        MDRread;
    logic [4:0]  ALUcode;
    logic [31:0] temp;
    logic        tempEnable;

    modport master (
        output regIn, HiIn, LoIn, ZIn, PCIn, MDRIn, YIn,
        output regOut, HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
        output Mdata, MDRread, ALUcode, temp, tempEnable
    );

    modport slave (
        input regIn, HiIn, LoIn, ZIn, PCIn, MDRIn, YIn,
        input regOut, HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
        input Mdata, MDRread, ALUcode, temp, tempEnable
    );

endinterface

// File: rtl/risc_datapath_alu.sv
// Combinational ALU producing a 64-bit result from Y (A) and the bus (B).
// MUL/DIV exist only when DATAPATH_MULDIV_EN is defined; otherwise those codes yield 0.
module risc_alu
    import risc_pkg::*;
(
    input  logic [WORD-1:0]   A,
    input  logic [WORD-1:0]   B,
    input  logic [4:0]        op,
    output logic [2*WORD-1:0] result
);

    logic [4:0]      sh;
    logic [WORD-1:0] rotR;
    logic [WORD-1:0] rotL;

    // Rotates shift a doubled copy of A so the wrapped bits fall into place.
    assign sh   = B[4:0];
    assign rotR = WORD'({A, A} >> sh);
    assign rotL = WORD'(({A, A} << sh) >> WORD);

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WORD-1:0] product;
    logic signed [WORD-1:0]   quotient;
    logic signed [WORD-1:0]   remainder;

    assign product   = $signed({{WORD{A[WORD-1]}}, A}) * $signed({{WORD{B[WORD-1]}}, B});
    assign quotient  = (B == '0) ? '1 : $signed(A) / $signed(B);
    assign remainder = (B == '0) ? $signed(A) : $signed(A) % $signed(B);
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {{WORD{1'b0}}, A + B};
            OP_SUB:  result = {{WORD{1'b0}}, A - B};
            OP_AND:  result = {{WORD{1'b0}}, A & B};
            OP_OR:   result = {{WORD{1'b0}}, A | B};
            OP_ROR:  result = {{WORD{1'b0}}, rotR};
            OP_ROL:  result = {{WORD{1'b0}}, rotL};
            OP_SHR:  result = {{WORD{1'b0}}, A >> sh};
            OP_SHRA: result = {{WORD{1'b0}}, $signed(A) >>> sh};
            OP_SHL:  result = {{WORD{1'b0}}, A << sh};
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  result = product;
            OP_DIV:  result = {remainder, quotient};
`else
            OP_MUL:  result = '0;
            OP_DIV:  result = '0;
`endif
            OP_NEG:  result = {{WORD{1'b0}}, -B};
            OP_NOT:  result = {{WORD{1'b0}}, ~B};
            default: result = {{WORD{1'b0}}, B};
        endcase
    end

endmodule

// File: rtl/risc_datapath_reg.sv
// Generic 32-bit load-enable register with asynchronous active-high clear.
module risc_reg32
    import risc_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic            load_i,
    input  logic [WORD-1:0] d_i,
    output logic [WORD-1:0] q_o
);

    logic [WORD-1:0] data_q;
    logic [WORD-1:0] data_d;

    always_comb begin
        data_d = load_i ? d_i : data_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/risc_datapath.sv
// Single-bus datapath: 16 GPRs, HI/LO, PC, MDR, Y and 64-bit Z around one priority-muxed bus.
// Define DATAPATH_MULDIV_EN to build the ALU's multiply and divide.
module risc_datapath
    import risc_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    risc_datapath_if.slave    ctrl
);

    logic [WORD-1:0]   bus;
    logic [WORD-1:0]   gpr_q [16];
    logic [WORD-1:0]   hi_q;
    logic [WORD-1:0]   lo_q;
    logic [WORD-1:0]   pc_q;
    logic [WORD-1:0]   mdr_q;
    logic [WORD-1:0]   mdr_d;
    logic [WORD-1:0]   y_q;
    logic [WORD-1:0]   zHi_q;
    logic [WORD-1:0]   zLo_q;
    logic [2*WORD-1:0] z_q;
    logic [2*WORD-1:0] aluResult;

    // Lowest priority is assigned first so later, higher-priority drivers win.
    always_comb begin
        bus = '0;
        if (ctrl.MDROut) bus = mdr_q;
        if (ctrl.PCOut)  bus = pc_q;
        if (ctrl.ZLoOut) bus = zLo_q;
        if (ctrl.ZHiOut) bus = zHi_q;
        if (ctrl.LoOut)  bus = lo_q;
        if (ctrl.HiOut)  bus = hi_q;
        for (int n = 15; n >= 0; n--) begin
            if (ctrl.regOut[n]) bus = gpr_q[n];
        end
        if (ctrl.tempEnable) bus = ctrl.temp;
    end

    for (genvar n = 0; n < 16; n++) begin : gGpr
        risc_reg32 uGpr (
            .clock  (clock),
            .clear  (clear),
            .load_i (ctrl.regIn[n]),
            .d_i    (bus),
            .q_o    (gpr_q[n])
        );
    end

    risc_reg32 uHi (.clock(clock), .clear(clear), .load_i(ctrl.HiIn), .d_i(bus), .q_o(hi_q));
    risc_reg32 uLo (.clock(clock), .clear(clear), .load_i(ctrl.LoIn), .d_i(bus), .q_o(lo_q));
    risc_reg32 uPc (.clock(clock), .clear(clear), .load_i(ctrl.PCIn), .d_i(bus), .q_o(pc_q));
    risc_reg32 uY  (.clock(clock), .clear(clear), .load_i(ctrl.YIn),  .d_i(bus), .q_o(y_q));

    assign mdr_d = ctrl.MDRread ? ctrl.Mdata : bus;
    risc_reg32 uMdr (.clock(clock), .clear(clear), .load_i(ctrl.MDRIn), .d_i(mdr_d), .q_o(mdr_q));

    risc_alu uAlu (
        .A      (y_q),
        .B      (bus),
        .op     (ctrl.ALUcode),
        .result (aluResult)
    );

    risc_reg32 uZHi (.clock(clock), .clear(clear), .load_i(ctrl.ZIn), .d_i(aluResult[2*WORD-1:WORD]), .q_o(zHi_q));
    risc_reg32 uZLo (.clock(clock), .clear(clear), .load_i(ctrl.ZIn), .d_i(aluResult[WORD-1:0]),      .q_o(zLo_q));

    assign z_q = {zHi_q, zLo_q};

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed test-plan steps plus randomized cycles
// checked against a behavioural register/ALU model.
module tb_risc_datapath;

    logic clock;
    logic clear;

    risc_datapath_if dpIf ();

    risc_datapath dut (
        .clock (clock),
        .clear (clear),
        .ctrl  (dpIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [31:0] mR [16];
    logic [31:0] mHi, mLo, mPc, mMdr, mY;
    logic [63:0] mZ;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int n = 0; n < 16; n++) mR[n] = '0;
        mHi = '0; mLo = '0; mPc = '0; mMdr = '0; mY = '0; mZ = '0;
    endtask

    // Reference ALU written bit-by-bit / with wide integer arithmetic from the opcode table.
    function automatic logic [63:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int          sh;
        logic [31:0] lo;
        longint      sa, sb, q, r;
        sh = int'(b[4:0]);
        lo = '0;
        case (op)
            5'b00011: lo = a + b;
            5'b00100: lo = a - b;
            5'b00101: lo = a & b;
            5'b00110: lo = a | b;
            5'b00111: for (int i = 0; i < 32; i++) lo[i] = a[(i + sh) % 32];
            5'b01000: for (int i = 0; i < 32; i++) lo[(i + sh) % 32] = a[i];
            5'b01001: for (int i = 0; i < 32; i++) lo[i] = (i + sh < 32) ? a[i + sh] : 1'b0;
            5'b01010: for (int i = 0; i < 32; i++) lo[i] = (i + sh < 32) ? a[i + sh] : a[31];
            5'b01011: for (int i = 0; i < 32; i++) lo[i] = (i >= sh) ? a[i - sh] : 1'b0;
            5'b01100: begin
`ifdef DATAPATH_MULDIV_EN
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                return 64'(sa * sb);
`else
                return 64'h0;
`endif
            end
            5'b01101: begin
`ifdef DATAPATH_MULDIV_EN
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
`else
                return 64'h0;
`endif
            end
            5'b01110: lo = 32'h0 - b;
            5'b01111: lo = ~b;
            default:  lo = b;
        endcase
        return {32'h0, lo};
    endfunction

    function automatic logic [31:0] modelBus();
        if (dpIf.tempEnable) return dpIf.temp;
        for (int n = 0; n < 16; n++) if (dpIf.regOut[n]) return mR[n];
        if (dpIf.HiOut)  return mHi;
        if (dpIf.LoOut)  return mLo;
        if (dpIf.ZHiOut) return mZ[63:32];
        if (dpIf.ZLoOut) return mZ[31:0];
        if (dpIf.PCOut)  return mPc;
        if (dpIf.MDROut) return mMdr;
        return 32'h0;
    endfunction

    task automatic idleControls();
        dpIf.regIn = '0; dpIf.HiIn = 0; dpIf.LoIn = 0; dpIf.ZIn = 0;
        dpIf.PCIn = 0; dpIf.MDRIn = 0; dpIf.YIn = 0;
        dpIf.regOut = '0; dpIf.HiOut = 0; dpIf.LoOut = 0; dpIf.ZHiOut = 0;
        dpIf.ZLoOut = 0; dpIf.PCOut = 0; dpIf.MDROut = 0;
        dpIf.Mdata = '0; dpIf.MDRread = 0; dpIf.ALUcode = '0;
        dpIf.temp = '0; dpIf.tempEnable = 0;
    endtask

    task automatic checkState(input string where);
        for (int n = 0; n < 16; n++)
            checkOutput($sformatf("%s R%0d", where, n), {32'h0, dut.gpr_q[n]}, {32'h0, mR[n]});
        checkOutput({where, " HI"},  {32'h0, dut.hi_q},  {32'h0, mHi});
        checkOutput({where, " LO"},  {32'h0, dut.lo_q},  {32'h0, mLo});
        checkOutput({where, " PC"},  {32'h0, dut.pc_q},  {32'h0, mPc});
        checkOutput({where, " MDR"}, {32'h0, dut.mdr_q}, {32'h0, mMdr});
        checkOutput({where, " Y"},   {32'h0, dut.y_q},   {32'h0, mY});
        checkOutput({where, " Z"},   dut.z_q,            mZ);
    endtask

    // Checks the bus for the current controls, clocks one edge, then checks every register.
    task automatic applyStimulus(input string where);
        logic [31:0] b;
        b = modelBus();
        #1;
        checkOutput({where, " bus"}, {32'h0, dut.bus}, {32'h0, b});
        @(posedge clock);
        #1;
        if (dpIf.ZIn) mZ = aluModel(mY, b, dpIf.ALUcode);
        for (int n = 0; n < 16; n++) if (dpIf.regIn[n]) mR[n] = b;
        if (dpIf.HiIn)  mHi = b;
        if (dpIf.LoIn)  mLo = b;
        if (dpIf.PCIn)  mPc = b;
        if (dpIf.YIn)   mY = b;
        if (dpIf.MDRIn) mMdr = dpIf.MDRread ? dpIf.Mdata : b;
        checkState(where);
    endtask

    task automatic randomControls();
        int mode;
        idleControls();
        dpIf.tempEnable = ($urandom_range(3) == 0);
        dpIf.temp = ($urandom_range(2) == 0) ? 32'($urandom_range(40)) : $urandom;
        mode = int'($urandom_range(2));
        if (mode == 1) dpIf.regOut = 16'h1 << $urandom_range(15);
        if (mode == 2) dpIf.regOut = 16'($urandom) & 16'($urandom);
        dpIf.HiOut  = ($urandom_range(7) == 0);
        dpIf.LoOut  = ($urandom_range(7) == 0);
        dpIf.ZHiOut = ($urandom_range(7) == 0);
        dpIf.ZLoOut = ($urandom_range(7) == 0);
        dpIf.PCOut  = ($urandom_range(7) == 0);
        dpIf.MDROut = ($urandom_range(7) == 0);
        dpIf.regIn  = 16'($urandom) & 16'($urandom);
        dpIf.HiIn   = ($urandom_range(2) == 0);
        dpIf.LoIn   = ($urandom_range(2) == 0);
        dpIf.PCIn   = ($urandom_range(2) == 0);
        dpIf.YIn    = ($urandom_range(2) == 0);
        dpIf.ZIn    = ($urandom_range(1) == 0);
        dpIf.MDRIn  = ($urandom_range(2) == 0);
        dpIf.MDRread = ($urandom_range(1) == 0);
        dpIf.Mdata  = $urandom;
        dpIf.ALUcode = ($urandom_range(3) != 0) ? 5'($urandom_range(15, 3)) : 5'($urandom_range(31));
        // The most-negative / -1 division overflows a 32-bit quotient; leave it out.
        if (dpIf.ZIn && dpIf.ALUcode == 5'b01101 && mY == 32'h80000000 && modelBus() == 32'hFFFFFFFF)
            dpIf.ZIn = 0;
    endtask

    logic [63:0] expMul, expDiv;
    logic [31:0] expHi;

    initial begin
`ifdef DATAPATH_MULDIV_EN
        expMul = 64'hFFFFFFFF_FFFFFFFA;
        expHi  = 32'hFFFFFFFF;
        expDiv = 64'h00000007_FFFFFFFF;
`else
        expMul = 64'h0;
        expHi  = 32'h0;
        expDiv = 64'h0;
`endif
        clear = 1'b1;
        idleControls();
        modelReset();
        @(posedge clock);
        #1;
        checkState("reset");
        checkOutput("reset bus", {32'h0, dut.bus}, 64'h0);
        @(negedge clock);
        clear = 1'b0;

        idleControls(); dpIf.temp = 32'hE3; dpIf.tempEnable = 1; dpIf.regIn = 16'h0008;
        applyStimulus("injR3");
        checkOutput("R3 inject", {32'h0, dut.gpr_q[3]}, 64'hE3);
        idleControls(); dpIf.temp = 32'h4; dpIf.tempEnable = 1; dpIf.regIn = 16'h0080;
        applyStimulus("injR7");
        checkOutput("R7 inject", {32'h0, dut.gpr_q[7]}, 64'h4);

        idleControls(); dpIf.regOut = 16'h0008; dpIf.YIn = 1;
        applyStimulus("rorY");
        checkOutput("ROR Y", {32'h0, dut.y_q}, 64'hE3);
        idleControls(); dpIf.regOut = 16'h0080; dpIf.ZIn = 1; dpIf.ALUcode = 5'b00111;
        applyStimulus("rorZ");
        checkOutput("ROR Z", dut.z_q, 64'h00000000_3000000E);
        idleControls(); dpIf.ZLoOut = 1; dpIf.regIn = 16'h0010;
        applyStimulus("rorR4");
        checkOutput("ROR R4", {32'h0, dut.gpr_q[4]}, 64'h3000000E);

        idleControls(); dpIf.Mdata = 32'h3A1B8000; dpIf.MDRread = 1; dpIf.MDRIn = 1;
        applyStimulus("mdrLoad");
        checkOutput("MDR load", {32'h0, dut.mdr_q}, 64'h3A1B8000);
        idleControls(); dpIf.MDROut = 1; dpIf.PCIn = 1;
        applyStimulus("mdrToPc");
        checkOutput("PC from MDR", {32'h0, dut.pc_q}, 64'h3A1B8000);

        idleControls(); dpIf.temp = 32'hFFFFFFFE; dpIf.tempEnable = 1; dpIf.YIn = 1;
        applyStimulus("mulY");
        idleControls(); dpIf.temp = 32'h3; dpIf.tempEnable = 1; dpIf.ZIn = 1; dpIf.ALUcode = 5'b01100;
        applyStimulus("mulZ");
        checkOutput("MUL Z", dut.z_q, expMul);
        idleControls(); dpIf.ZHiOut = 1; dpIf.HiIn = 1;
        applyStimulus("mulHi");
        checkOutput("MUL HI", {32'h0, dut.hi_q}, {32'h0, expHi});
        idleControls(); dpIf.temp = 32'h7; dpIf.tempEnable = 1; dpIf.YIn = 1;
        applyStimulus("divY");
        idleControls(); dpIf.temp = 32'h0; dpIf.tempEnable = 1; dpIf.ZIn = 1; dpIf.ALUcode = 5'b01101;
        applyStimulus("divZ");
        checkOutput("DIV by 0", dut.z_q, expDiv);

        // Shift amount 32 has B[4:0] = 0, so Y passes through unchanged.
        idleControls(); dpIf.temp = 32'h20; dpIf.tempEnable = 1; dpIf.ZIn = 1; dpIf.ALUcode = 5'b01001;
        applyStimulus("shr0");
        checkOutput("SHR by 0", dut.z_q, 64'h7);

        idleControls(); dpIf.temp = 32'h11; dpIf.tempEnable = 1; dpIf.regIn = 16'h0004;
        applyStimulus("prioR2");
        idleControls(); dpIf.temp = 32'h22; dpIf.tempEnable = 1; dpIf.regIn = 16'h0020;
        applyStimulus("prioR5");
        idleControls(); dpIf.regOut = 16'h0024;
        #1;
        checkOutput("bus priority", {32'h0, dut.bus}, 64'h11);
        idleControls();
        #1;
        checkOutput("bus idle", {32'h0, dut.bus}, 64'h0);

        for (int i = 0; i < 400; i++) begin
            randomControls();
            applyStimulus($sformatf("rnd%0d", i));
        end

        // Asynchronous clear between edges, held across an edge with loads asserted.
        idleControls();
        dpIf.temp = 32'hDEADBEEF; dpIf.tempEnable = 1; dpIf.regIn = 16'hFFFF;
        dpIf.HiIn = 1; dpIf.LoIn = 1; dpIf.PCIn = 1; dpIf.YIn = 1; dpIf.ZIn = 1; dpIf.MDRIn = 1;
        dpIf.ALUcode = 5'b00011;
        @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        modelReset();
        checkState("clearNow");
        @(posedge clock);
        #1;
        checkState("clearHeld");
        #2;
        clear = 1'b0;
        idleControls();
        #1;
        checkState("clearDone");
        checkOutput("clear bus", {32'h0, dut.bus}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_datapath.md
# risc_datapath

32-bit single-bus datapath of the multi-cycle RISC CPU: sixteen general registers, HI/LO, PC, MDR, ALU operand register Y and 64-bit result register Z, all sharing one combinational bus. The external control unit, or the bench, drives one-hot register-out selects, register-in enables and an ALU opcode each step. A test-injection port lets a constant be forced onto the bus.

## Interface
Parameters: none.

Ports, in positional order:
- clock  in  1  system clock; all registers load on the rising edge.
- clear  in  1  reset, asynchronous, active-high; zeroes every register.
- regIn  in  16  per-GPR load enable; bit n loads Rn from the bus.
- HiIn, LoIn, ZIn, PCIn, MDRIn, YIn  in  1 each  load enables.
- regOut  in  16  per-GPR bus-drive select; bit n drives Rn.
- HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut  in  1 each  bus-drive selects.
- Mdata  in  32  memory read data.
- MDRread  in  1  MDR input mux select: 1 selects Mdata, 0 selects the bus.
- ALUcode  in  5  ALU operation.
- temp  in  32  injected bus value.
- tempEnable  in  1  drives temp onto the bus.

There are no output ports. Verification observes internal registers hierarchically: R0..R15, HI, LO, PC, MDR, Y, Z[63:0] and bus.

## Operation
**Bus**
- The bus is a combinational priority mux. Priority, highest first: tempEnable, regOut[0..15] (lowest index first), HiOut, LoOut, ZHiOut (Z[63:32]), ZLoOut (Z[31:0]), PCOut, MDROut.
- When no select is active, the bus is 0.

**Register loads**
- R0..R15, HI, LO, PC and Y load the bus when their In signal is high.
- R0 is an ordinary register, not hardwired to zero.
- MDR loads (MDRread ? Mdata : bus) when MDRIn is high.
- Z loads the 64-bit ALU result when ZIn is high.

**ALU**
Operand A is Y, operand B is the bus, and the result is 64 bits. Unless stated otherwise, the result is {32'b0, r}, where sh = B[4:0].
- 00011 ADD: A+B, wrapping.
- 00100 SUB: A−B, wrapping.
- 00101 AND.
- 00110 OR.
- 00111 ROR: A rotated right by sh.
- 01000 ROL: A rotated left by sh.
- 01001 SHR: logical right shift of A by sh.
- 01010 SHRA: arithmetic right shift of A by sh.
- 01011 SHL: left shift of A by sh.
- 01100 MUL: signed A×B, full 64-bit product; the high word lands in Z[63:32].
- 01101 DIV: signed; Z[31:0] = quotient, Z[63:32] = remainder. If B = 0, quotient = 32'hFFFFFFFF and remainder = A.
- 01110 NEG: −B.
- 01111 NOT: ~B.
- Any other code: pass B, i.e. {32'b0, B}.

**Boundaries**
- A rotate or shift by 0 returns A unchanged.
- Shift amounts use only B[4:0]; higher bits of B are ignored.

## Timing
- Bus and ALU are purely combinational within a cycle.
- Every load completes at the rising edge where its enable is high.
- A register both driving the bus and loading in the same cycle reloads its own old value.
- A register-to-register transfer takes 1 cycle.
- An ALU operation takes 2 cycles: Y load, then Z load. Reading Z back takes 1 further cycle.
- clear asserted at any time zeroes all registers immediately; it overrides any simultaneous load.
- Reset value of every register and of the bus (with no selects active): 0.

## Configuration
- DATAPATH_MULDIV_EN defined: MUL and DIV are implemented as specified.
- DATAPATH_MULDIV_EN undefined: codes 01100 and 01101 produce Z = 0 and no multiplier or divider is synthesised.

## Structure
- Shared package `risc_pkg` holds the ALUcode constants and the word width (32).
- Natural sub-module: `risc_alu`, combinational, with inputs A[31:0], B[31:0], op[4:0] and output result[63:0].
- A single `risc_reg32` load-enable register with asynchronous clear is instantiated for every 32-bit register.

## Test plan
- **Injection:** temp = 0xE3 with tempEnable and regIn[3] for one edge → R3 = 0x000000E3. temp = 4 into R7 → R7 = 4.
- **ROR:** regOut[3] with YIn; then regOut[7] with ZIn and ALUcode = 00111; then ZLoOut with regIn[4] → Y = 0xE3, Z = 0x00000000_3000000E, R4 = 0x3000000E.
- **MDR:** Mdata = 0x3A1B8000, MDRread = 1, MDRIn = 1 → MDR = 0x3A1B8000. MDROut with PCIn → PC = 0x3A1B8000.
- **MUL:** Y = 0xFFFFFFFE (−2), bus = 3, ALUcode = 01100 → Z = 0xFFFFFFFF_FFFFFFFA. ZHiOut → HI. DIV 7/0 → Z = {7, 0xFFFFFFFF}.
- **Bus priority:** regOut[2] and regOut[5] active together with R2 = 0x11, R5 = 0x22 → bus = 0x11. No select active → bus = 0.
- **Reset:** clear pulsed mid-sequence between clock edges → all registers read 0 immediately, and loads asserted during clear are ignored.
